mx_vector_streamer: RTL and testbench

MX_VECTOR_STREAMER -- requirements
Module: mx_vector_streamer

---
 rtl/mx_vector_streamer.sv | 142 ++++++++++++++
 tb/tb_mx_vector_streamer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mx_vector_streamer.sv
// MX block streamer: captures one scaled MX vector and emits it LANES elements per beat.
// Optional NaN/Inf lane flags are enabled with the MX_STREAMER_SPECIAL_DETECT_EN macro.
module mx_vector_streamer #(
  parameter int BLOCK_SIZE = 32,
  parameter int LANES      = 4,
  localparam int VEC_W     = 8 + 8*BLOCK_SIZE,
  localparam int BEATS     = BLOCK_SIZE / LANES,
  localparam int BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         in_fmt,
  input  logic [VEC_W-1:0]   in_vec,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [7:0]         out_scale,
  output logic [8*LANES-1:0] out_elem,
  output logic [2:0]         out_fmt,
  output logic [BEAT_W-1:0]  out_beat,
  output logic               out_last,
  output logic               err_fmt
`ifdef MX_STREAMER_SPECIAL_DETECT_EN
  ,
  output logic [LANES-1:0]   out_special
`endif
);

  if (BLOCK_SIZE % LANES != 0) begin : g_bad_cfg
    $error("mx_vector_streamer: BLOCK_SIZE must be a multiple of LANES");
  end

  typedef enum logic {IDLE, STREAM} state_e;

  state_e                    state_q, state_d;
  logic [8*BLOCK_SIZE-1:0]   vec_q, vec_d;
  logic [7:0]                scale_q, scale_d;
  logic [2:0]                fmt_q, fmt_d;
  logic [BEAT_W-1:0]         beat_q, beat_d;
  logic                      err_q, err_d;

  logic accept, legal, out_hs, last_beat;

  // Element idx of the packed vector, zero-extended to a byte.
  function automatic logic [7:0] lane_val(input logic [8*BLOCK_SIZE-1:0] v,
                                          input logic [2:0] fmt, input int idx);
    logic [8*BLOCK_SIZE-1:0] s;
    logic [7:0]              r;
    r = '0;
    case (fmt)
      3'd0, 3'd1, 3'd5: begin s = v >> (idx*8); r = s[7:0]; end
      3'd2, 3'd3:       begin s = v >> (idx*6); r = {2'b00, s[5:0]}; end
      3'd4:             begin s = v >> (idx*4); r = {4'b0000, s[3:0]}; end
      default:          r = '0;
    endcase
    return r;
  endfunction

  assign last_beat = (beat_q == BEAT_W'(BEATS-1));
  assign out_valid = (state_q == STREAM);
  assign out_last  = out_valid && last_beat;
  assign out_hs    = out_valid && out_ready;
  assign in_ready  = (state_q == IDLE) || (out_hs && last_beat);
  assign accept    = in_valid && in_ready;
  assign legal     = (in_fmt <= 3'd5);

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    scale_d = scale_q;
    fmt_d   = fmt_q;
    beat_d  = beat_q;
    err_d   = 1'b0;
    if (out_hs) begin
      if (last_beat) begin
        state_d = IDLE;
        beat_d  = '0;
      end else begin
        beat_d  = beat_q + BEAT_W'(1);
      end
    end
    // A new block may land in the same cycle the previous one retires.
    if (accept) begin
      if (legal) begin
        state_d = STREAM;
        vec_d   = in_vec[8*BLOCK_SIZE-1:0];
        scale_d = in_vec[8*BLOCK_SIZE +: 8];
        fmt_d   = in_fmt;
        beat_d  = '0;
      end else begin
        err_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vec_q   <= '0;
      scale_q <= '0;
      fmt_q   <= '0;
      beat_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      scale_q <= scale_d;
      fmt_q   <= fmt_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
    end
  end

  assign out_scale = scale_q;
  assign out_fmt   = fmt_q;
  assign out_beat  = beat_q;
  assign err_fmt   = err_q;

  always_comb begin
    out_elem = '0;
    for (int k = 0; k < LANES; k++) begin
      out_elem[8*k +: 8] = lane_val(vec_q, fmt_q, int'(beat_q)*LANES + k);
    end
  end

`ifdef MX_STREAMER_SPECIAL_DETECT_EN
  // A saturated block scale marks the whole block as non-finite.
  always_comb begin
    out_special = '0;
    for (int k = 0; k < LANES; k++) begin
      if (scale_q == 8'hFF)
        out_special[k] = 1'b1;
      else if (fmt_q == 3'd0)
        out_special[k] = (out_elem[8*k+2 +: 5] == 5'h1F);
      else if (fmt_q == 3'd1)
        out_special[k] = (out_elem[8*k+3 +: 4] == 4'hF) && (out_elem[8*k +: 3] == 3'h7);
    end
  end
`endif

endmodule

// File: tb/tb_mx_vector_streamer.sv
// Self-checking bench for mx_vector_streamer: queue-based block model plus directed vectors.
module tb_mx_vector_streamer;
  localparam int BS = 32;
  localparam int L  = 4;
  localparam int VW = 8 + 8*BS;
  localparam int NB = BS / L;
  localparam int BW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, out_valid, out_ready, out_last, err_fmt;
  logic [2:0]    in_fmt, out_fmt;
  logic [VW-1:0] in_vec;
  logic [7:0]    out_scale;
  logic [8*L-1:0] out_elem;
  logic [BW-1:0] out_beat;
`ifdef MX_STREAMER_SPECIAL_DETECT_EN
  logic [L-1:0]  out_special;
`endif

  mx_vector_streamer #(.BLOCK_SIZE(BS), .LANES(L)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt), .in_vec(in_vec),
    .out_valid(out_valid), .out_ready(out_ready), .out_scale(out_scale),
    .out_elem(out_elem), .out_fmt(out_fmt), .out_beat(out_beat),
    .out_last(out_last), .err_fmt(err_fmt)
`ifdef MX_STREAMER_SPECIAL_DETECT_EN
    , .out_special(out_special)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]     scale;
    logic [2:0]     fmt;
    logic [8*L-1:0] elem;
    logic [BW-1:0]  beat;
    logic           last;
    logic [L-1:0]   spec;
  } beat_t;

  beat_t q[$];
  logic  err_exp;
  int    n_cmp = 0;
  int    n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int ew_of(input logic [2:0] fmt);
    case (fmt)
      3'd2, 3'd3: return 6;
      3'd4:       return 4;
      default:    return 8;
    endcase
  endfunction

  function automatic logic [7:0] elem_of(input logic [VW-1:0] v, input logic [2:0] fmt, input int i);
    logic [7:0] e = '0;
    int ew = ew_of(fmt);
    for (int j = 0; j < ew; j++) e[j] = v[i*ew + j];
    return e;
  endfunction

  // mode 0: element i = i; 1: i%8; 2: random; 3: NaN/Inf patterns in elements 0 and 5
  function automatic logic [VW-1:0] mk(input logic [2:0] fmt, input logic [7:0] sc, input int mode);
    logic [VW-1:0] v = '0;
    logic [7:0] val;
    int ew = ew_of(fmt);
    for (int i = 0; i < BS; i++) begin
      case (mode)
        0: val = 8'(i);
        1: val = 8'(i % 8);
        2: val = 8'($urandom);
        default: val = (i == 0) ? 8'h7C : (i == 5) ? 8'h7F : 8'(i);
      endcase
      for (int j = 0; j < ew; j++) v[i*ew + j] = val[j];
    end
    v[8*BS +: 8] = sc;
    return v;
  endfunction

  // Model: on acceptance of a legal vector, queue every beat it must produce.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      err_exp = 1'b0;
    end else begin
      logic rdy_m, acc;
      rdy_m = (q.size() == 0) || (q[0].last && out_ready);
      acc = in_valid && rdy_m;
      if (q.size() > 0 && out_ready) void'(q.pop_front());
      err_exp = acc && (in_fmt > 3'd5);
      if (acc && in_fmt <= 3'd5) begin
        for (int b = 0; b < NB; b++) begin
          beat_t t;
          t.scale = in_vec[8*BS +: 8];
          t.fmt   = in_fmt;
          t.beat  = BW'(b);
          t.last  = (b == NB-1);
          t.elem  = '0;
          t.spec  = '0;
          for (int k = 0; k < L; k++) begin
            logic [7:0] e;
            e = elem_of(in_vec, in_fmt, b*L + k);
            t.elem[8*k +: 8] = e;
            if (t.scale == 8'hFF) t.spec[k] = 1'b1;
            else if (in_fmt == 3'd0) t.spec[k] = (e[6:2] == 5'h1F);
            else if (in_fmt == 3'd1) t.spec[k] = (e[6:3] == 4'hF) && (e[2:0] == 3'h7);
          end
          q.push_back(t);
        end
      end
    end
  end

  // Compare process
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      logic ev;
      ev = (q.size() > 0);
      chk("out_valid", out_valid, ev);
      chk("in_ready", in_ready, !ev || (q[0].last && out_ready));
      chk("err_fmt", err_fmt, err_exp);
      if (ev) begin
        chk("out_scale", out_scale, q[0].scale);
        chk("out_fmt", out_fmt, q[0].fmt);
        chk("out_elem", out_elem, q[0].elem);
        chk("out_beat", out_beat, q[0].beat);
        chk("out_last", out_last, q[0].last);
`ifdef MX_STREAMER_SPECIAL_DETECT_EN
        chk("out_special", out_special, q[0].spec);
`endif
      end
    end
  end

  task automatic tick(); @(posedge clk); #1; endtask
  task automatic smp(); @(negedge clk); endtask

  task automatic send(input logic [2:0] fmt, input logic [VW-1:0] v);
    in_fmt = fmt; in_vec = v; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    smp();
    while (out_valid === 1'b1 && n < 40) begin smp(); n++; end
    if (n >= 40) chk("drain_timeout", 1, 0);
    tick();
  endtask

  logic [8*L-1:0] held;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_fmt = '0; in_vec = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    smp();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_beat", out_beat, 0);
    chk("rst_out_scale", out_scale, 0);
    chk("rst_out_elem", out_elem, 0);
    chk("rst_out_fmt", out_fmt, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_err_fmt", err_fmt, 0);
    #2 rst_n = 1'b1;
    tick();

    // E4M3, element i = i, scale 7F
    send(3'd1, mk(3'd1, 8'h7F, 0));
    smp();
    chk("a_valid_lat1", out_valid, 1);
    chk("a_beat0", out_beat, 0);
    chk("a_elem0", out_elem, 32'h03020100);
    chk("a_scale", out_scale, 8'h7F);
    repeat (6) smp();
    smp();
    chk("a_beat7", out_beat, 7);
    chk("a_elem7", out_elem, 32'h1F1E1D1C);
    chk("a_last7", out_last, 1);
    tick();
    smp();
    chk("a_idle", out_valid, 0);
    tick();

    // E2M1, element i = i%8
    send(3'd4, mk(3'd4, 8'h10, 1));
    smp();
    smp();
    chk("b_elem1", out_elem, 32'h07060504);
    chk("b_fmt", out_fmt, 4);
    drain();

    // E5M2 random, stall 3 cycles at beat 2
    send(3'd0, mk(3'd0, 8'h33, 2));
    tick();
    tick();
    out_ready = 1'b0;
    smp();
    held = out_elem;
    chk("c_beat2", out_beat, 2);
    for (int c = 0; c < 3; c++) begin
      tick();
      smp();
      chk("c_stall_beat", out_beat, 2);
      chk("c_stall_elem", out_elem, held);
    end
    out_ready = 1'b1;
    drain();

    // FP6 and INT8 random content; INT8 block uses a saturated scale
    send(3'd2, mk(3'd2, 8'h05, 2)); drain();
    send(3'd3, mk(3'd3, 8'h06, 2)); drain();
    send(3'd5, mk(3'd5, 8'hFF, 2)); drain();

    // Back-to-back: second block offered on the first block's last beat
    send(3'd1, mk(3'd1, 8'h21, 2));
    begin
      int n = 0;
      smp();
      while (out_last !== 1'b1 && n < 20) begin smp(); n++; end
      if (n >= 20) chk("e_last_timeout", 1, 0);
    end
    in_fmt = 3'd5; in_vec = mk(3'd5, 8'h42, 2); in_valid = 1'b1;
    #1 chk("e_in_ready_last", in_ready, 1);
    tick();
    in_valid = 1'b0;
    smp();
    chk("e_valid", out_valid, 1);
    chk("e_beat0", out_beat, 0);
    chk("e_scale", out_scale, 8'h42);
    drain();

    // Illegal format
    send(3'd6, mk(3'd0, 8'h11, 2));
    smp();
    chk("f_err_hi", err_fmt, 1);
    chk("f_valid", out_valid, 0);
    tick();
    smp();
    chk("f_err_lo", err_fmt, 0);
    chk("f_valid2", out_valid, 0);
    tick();

    // E5M2 with exponent-31 lanes
    send(3'd0, mk(3'd0, 8'h01, 3));
    smp();
    chk("g_elem0", out_elem, 32'h0302017C);
`ifdef MX_STREAMER_SPECIAL_DETECT_EN
    chk("g_special0", out_special, 4'b0001);
`endif
    drain();

    // Reset in the middle of a block at beat 3
    send(3'd1, mk(3'd1, 8'h55, 0));
    repeat (4) smp();
    chk("h_beat3", out_beat, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("h_rst_valid", out_valid, 0);
    chk("h_rst_beat", out_beat, 0);
    chk("h_rst_elem", out_elem, 0);
    chk("h_rst_last", out_last, 0);
    tick();
    rst_n = 1'b1;
    smp();
    chk("h_in_ready", in_ready, 1);
    chk("h_valid_after", out_valid, 0);
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
